// File: rtl/seq_restoring_divider.sv
// Sequential restoring divider: one quotient bit per clock, MSB first.
// Unsigned DIVIDEND_W / DIVISOR_W divide with start/busy/done handshake.
// Optional macro DIV_ZERO_FAST_EN: a zero divisor completes after a single
// shortcut iteration instead of the full DIVIDEND_W iterations.
module seq_restoring_divider #(
  parameter int DIVIDEND_W = 8,
  parameter int DIVISOR_W  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic                  busy,
  output logic                  done,
  output logic [DIVIDEND_W-1:0] quotient,
  output logic [DIVISOR_W-1:0]  remainder,
  output logic                  div_by_zero
);

  localparam int CNT_W = $clog2(DIVIDEND_W + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIVIDEND_W - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                state_q, state_d;
  // Dividend shifts out at the top while quotient bits shift in at the bottom,
  // so after the last iteration this register holds the quotient.
  logic [DIVIDEND_W-1:0] dvd_q, dvd_d;
  logic [DIVISOR_W-1:0]  dvs_q, dvs_d;
  logic                  zero_q, zero_d;
  // Low dividend bits kept aside: they become the remainder of a divide by zero.
  logic [DIVISOR_W-1:0]  zrem_q, zrem_d;
  logic [DIVISOR_W:0]    prem_q, prem_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DIVIDEND_W-1:0] quo_q, quo_d;
  logic [DIVISOR_W-1:0]  rem_q, rem_d;
  logic                  dbz_q, dbz_d;

  logic [DIVISOR_W+1:0]  trial;
  logic                  qbit;

  // Trial subtraction of the divisor from the shifted partial remainder; the
  // extra top bit is the sign, clear means the subtraction did not go negative.
  always_comb begin
    trial = {prem_q, dvd_q[DIVIDEND_W-1]} - {2'b00, dvs_q};
    qbit  = ~trial[DIVISOR_W+1];
  end

  // Next-state, datapath update and result capture.
  always_comb begin
    state_d = state_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    zero_d  = zero_q;
    zrem_d  = zrem_q;
    prem_d  = prem_q;
    cnt_d   = cnt_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;

    case (state_q)
      RUN: begin
        prem_d = qbit ? trial[DIVISOR_W:0]
                      : {prem_q[DIVISOR_W-1:0], dvd_q[DIVIDEND_W-1]};
        dvd_d  = {dvd_q[DIVIDEND_W-2:0], qbit};
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          state_d = DONE;
          quo_d   = zero_q ? '1 : dvd_d;
          rem_d   = zero_q ? zrem_q : prem_d[DIVISOR_W-1:0];
          dbz_d   = zero_q;
        end
      end
      default: begin
        // IDLE and DONE both accept a new request; DONE otherwise falls to IDLE.
        if (state_q == DONE) state_d = IDLE;
        if (start) begin
          state_d = RUN;
          dvd_d   = dividend;
          dvs_d   = divisor;
          zero_d  = (divisor == '0);
          zrem_d  = dividend[DIVISOR_W-1:0];
          prem_d  = '0;
`ifdef DIV_ZERO_FAST_EN
          // A zero divisor jumps straight to the final iteration.
          cnt_d   = (divisor == '0) ? LAST : '0;
`else
          cnt_d   = '0;
`endif
        end
      end
    endcase
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      dvd_q   <= '0;
      dvs_q   <= '0;
      zero_q  <= 1'b0;
      zrem_q  <= '0;
      prem_q  <= '0;
      cnt_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      zero_q  <= zero_d;
      zrem_q  <= zrem_d;
      prem_q  <= prem_d;
      cnt_q   <= cnt_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
    end
  end

  assign busy        = (state_q == RUN);
  assign done        = (state_q == DONE);
  assign quotient    = quo_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Bench for seq_restoring_divider: directed divides plus a few random ones,
// expected results queued at start and checked when done pulses.
module tb_seq_restoring_divider;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] dividend = 8'd0;
  logic [3:0] divisor = 4'd0;
  logic       busy, done, div_by_zero;
  logic [7:0] quotient;
  logic [3:0] remainder;

  seq_restoring_divider #(.DIVIDEND_W(8), .DIVISOR_W(4)) dut (
    .clk(clk), .rst(rst), .start(start), .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

`ifdef DIV_ZERO_FAST_EN
  localparam int ZLAT = 2;
`else
  localparam int ZLAT = 9;
`endif

  typedef struct {
    logic [7:0] q;
    logic [3:0] r;
    logic       z;
    int         lat;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad = 0;
  int t0 = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // Drive a one-cycle start at a negedge and queue the expected result.
  task automatic push_start(input logic [7:0] a, input logic [3:0] b);
    exp_t e;
    if (b == 4'd0) begin
      e.q = 8'hFF; e.r = a[3:0]; e.z = 1'b1; e.lat = ZLAT;
    end else begin
      e.q = a / {4'd0, b}; e.r = 4'(a % {4'd0, b}); e.z = 1'b0; e.lat = 9;
    end
    sb.push_back(e);
    start = 1'b1; dividend = a; divisor = b;
    @(negedge clk);
    start = 1'b0;
    t0 = cyc;
    chk("busy_after_start", busy, 1);
  endtask

  // Wait (bounded) for done, then compare against the oldest queued result.
  task automatic wait_done(input string tag);
    exp_t e;
    int n = 0;
    while (done !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_done_seen"}, done, 1);
    chk({tag, "_sb_nonempty"}, sb.size() > 0, 1);
    if (done === 1'b1 && sb.size() > 0) begin
      e = sb.pop_front();
      chk({tag, "_quotient"}, quotient, e.q);
      chk({tag, "_remainder"}, remainder, e.r);
      chk({tag, "_dbz"}, div_by_zero, e.z);
      chk({tag, "_latency"}, cyc - t0 + 1, e.lat);
      chk({tag, "_busy_in_done"}, busy, 0);
    end
  endtask

  initial begin
    int hits;
    logic [7:0] ra;
    logic [3:0] rb;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_quotient", quotient, 0);
    chk("rst_remainder", remainder, 0);
    chk("rst_dbz", div_by_zero, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_no_done", done, 0);

    // 225 / 15, then check the results hold and done drops
    push_start(8'd225, 4'd15);
    wait_done("t1");
    @(negedge clk);
    chk("t1_done_low", done, 0);
    chk("t1_hold_q", quotient, 15);
    chk("t1_hold_r", remainder, 0);
    chk("t1_idle_busy", busy, 0);

    push_start(8'd200, 4'd7);   wait_done("t2");
    @(negedge clk);
    push_start(8'hFF, 4'd1);    wait_done("t3a");
    @(negedge clk);
    push_start(8'd3, 4'd9);     wait_done("t3b");
    @(negedge clk);
    push_start(8'hA5, 4'd0);    wait_done("t4_zero");
    @(negedge clk);
    chk("t4_hold_dbz", div_by_zero, 1);
    push_start(8'd9, 4'd2);     wait_done("t4_after");

    // Start during a busy divide is ignored
    @(negedge clk);
    push_start(8'd100, 4'd7);
    repeat (2) @(negedge clk);
    start = 1'b1; dividend = 8'd50; divisor = 4'd3;
    @(negedge clk);
    start = 1'b0;
    chk("t5_still_busy", busy, 1);
    wait_done("t5_ignored");

    // Back-to-back: second start issued in the DONE cycle
    @(negedge clk);
    push_start(8'd60, 4'd5);    wait_done("t5_b2b_first");
    push_start(8'd13, 4'd4);    wait_done("t5_b2b_second");
    push_start(8'hA5, 4'd0);    wait_done("t5_b2b_zero");
    push_start(8'd13, 4'd4);    wait_done("t5_b2b_after_zero");

    // Reset four cycles into a divide
    @(negedge clk);
    push_start(8'd200, 4'd7);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("t6_busy", busy, 0);
    chk("t6_done", done, 0);
    chk("t6_quotient", quotient, 0);
    chk("t6_remainder", remainder, 0);
    chk("t6_dbz", div_by_zero, 0);
    @(negedge clk);
    rst = 1'b0;
    sb.delete();
    hits = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done === 1'b1) hits++;
    end
    chk("t6_no_done_pulse", hits, 0);
    push_start(8'd77, 4'd6);    wait_done("t6_after");

    // A few random operands, including possible zero divisors
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      ra = 8'($urandom_range(0, 255));
      rb = 4'($urandom_range(0, 15));
      push_start(ra, rb);
      wait_done("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
